// File: rtl/sim_halt_monitor.sv
// rtl/sim_halt_monitor.sv - simulation halt monitor: breakpoint, self-loop and timeout detection
//
// Purpose: watches the retire stream of a simulated core while in RUN and
// stops it (HALTED) on the first halt condition. It reports the cause, the
// lowest matching breakpoint slot, cycles spent in RUN and instructions
// retired in RUN.
//
// Optional feature: define SIM_HALT_MONITOR_LOOP_DETECT_EN to build the
// self-loop detector (halt after LOOP_N consecutive identical retired PCs).
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rstn       in   asynchronous active-low reset
//   start      in   pulse, IDLE -> RUN
//   clr        in   pulse, HALTED -> IDLE with counters cleared
//   pc         in   [ADDR_W]         PC of the instruction retiring this cycle
//   pc_vld     in   retire strobe qualifying pc
//   bp_addr    in   [NUM_BP*ADDR_W]  halt addresses, slot i at [i*ADDR_W +: ADDR_W]
//   bp_en      in   [NUM_BP]         per-slot enable
//   timeout    in   [CNT_W]          RUN cycle limit, 0 disables
//   halt       out  high while HALTED
//   halt_cause out  [2]  00 none, 01 breakpoint, 10 self-loop, 11 timeout
//   hit_idx    out  [4]  lowest matching breakpoint slot (0 unless cause is 01)
//   cycle_cnt  out  [CNT_W]  cycles spent in RUN (saturating)
//   instr_cnt  out  [CNT_W]  retires seen in RUN (saturating)

module sim_halt_monitor #(
    parameter int ADDR_W = 32,
    parameter int NUM_BP = 4,
    parameter int CNT_W  = 32,
    parameter int LOOP_N = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic                       clr,
    input  logic [ADDR_W-1:0]          pc,
    input  logic                       pc_vld,
    input  logic [NUM_BP*ADDR_W-1:0]   bp_addr,
    input  logic [NUM_BP-1:0]          bp_en,
    input  logic [CNT_W-1:0]           timeout,
    output logic                       halt,
    output logic [1:0]                 halt_cause,
    output logic [3:0]                 hit_idx,
    output logic [CNT_W-1:0]           cycle_cnt,
    output logic [CNT_W-1:0]           instr_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_BP   = 2'b01;
    localparam logic [1:0] CAUSE_LOOP = 2'b10;
    localparam logic [1:0] CAUSE_TO   = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if (NUM_BP < 1 || NUM_BP > 16 || LOOP_N < 1) begin : g_param_check
        $error("sim_halt_monitor: NUM_BP must be 1..16 and LOOP_N >= 1");
    end

    state_t state, state_nxt;

    logic [CNT_W-1:0] cyc_inc;
    logic [CNT_W-1:0] ins_inc;
    logic [CNT_W:0]   cyc_plus1;
    logic             to_fire;
    logic             bp_hit;
    logic [3:0]       bp_idx;
    logic             loop_fire;
    logic             halt_now;
    logic [1:0]       cause_nxt;
    logic [3:0]       idx_nxt;

    // Saturating increments.
    assign cyc_inc = (cycle_cnt == CNT_MAX) ? cycle_cnt : cycle_cnt + CNT_ONE;
    assign ins_inc = (instr_cnt == CNT_MAX) ? instr_cnt : instr_cnt + CNT_ONE;

    // One bit wider so that cycle_cnt + 1 cannot wrap onto a small timeout.
    assign cyc_plus1 = {1'b0, cycle_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign to_fire   = (timeout != '0) && (cyc_plus1 == {1'b0, timeout});

    // Scan from the top so the lowest matching slot is the last one written.
    always_comb begin
        bp_hit = 1'b0;
        bp_idx = 4'd0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (pc_vld && bp_en[i] && (pc == bp_addr[i*ADDR_W +: ADDR_W])) begin
                bp_hit = 1'b1;
                bp_idx = 4'(i);
            end
        end
    end

`ifdef SIM_HALT_MONITOR_LOOP_DETECT_EN
    localparam int LW = $clog2(LOOP_N + 1);
    localparam logic [LW-1:0] LOOP_TGT = LW'(LOOP_N);
    localparam logic [LW-1:0] LOOP_ONE = LW'(1);

    logic [ADDR_W-1:0] last_pc;
    logic              last_vld;
    logic [LW-1:0]     loop_cnt;
    logic [LW-1:0]     loop_nxt;

    // Run length of identical retired PCs including this retire.
    always_comb begin
        loop_nxt = LOOP_ONE;
        if (last_vld && (pc == last_pc)) begin
            loop_nxt = (loop_cnt == LOOP_TGT) ? loop_cnt : loop_cnt + LOOP_ONE;
        end
    end

    assign loop_fire = pc_vld && (loop_nxt == LOOP_TGT);

    // History starts fresh on every RUN; frozen while HALTED.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_pc  <= '0;
            last_vld <= 1'b0;
            loop_cnt <= '0;
        end else if (state == ST_IDLE) begin
            last_pc  <= '0;
            last_vld <= 1'b0;
            loop_cnt <= '0;
        end else if (state == ST_RUN && pc_vld) begin
            last_pc  <= pc;
            last_vld <= 1'b1;
            loop_cnt <= loop_nxt;
        end
    end
`else
    assign loop_fire = 1'b0;
`endif

    // Priority: breakpoint > self-loop > timeout.
    always_comb begin
        halt_now  = 1'b0;
        cause_nxt = CAUSE_NONE;
        idx_nxt   = 4'd0;
        if (bp_hit) begin
            halt_now  = 1'b1;
            cause_nxt = CAUSE_BP;
            idx_nxt   = bp_idx;
        end else if (loop_fire) begin
            halt_now  = 1'b1;
            cause_nxt = CAUSE_LOOP;
        end else if (to_fire) begin
            halt_now  = 1'b1;
            cause_nxt = CAUSE_TO;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start)    state_nxt = ST_RUN;
            ST_RUN:    if (halt_now) state_nxt = ST_HALTED;
            ST_HALTED: if (clr)      state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counters and halt report. The triggering cycle is counted in the
    // same edge that enters HALTED.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cycle_cnt  <= '0;
            instr_cnt  <= '0;
            halt_cause <= CAUSE_NONE;
            hit_idx    <= 4'd0;
        end else begin
            case (state)
                ST_RUN: begin
                    cycle_cnt <= cyc_inc;
                    if (pc_vld) begin
                        instr_cnt <= ins_inc;
                    end
                    if (halt_now) begin
                        halt_cause <= cause_nxt;
                        hit_idx    <= idx_nxt;
                    end
                end
                ST_HALTED: begin
                    if (clr) begin
                        cycle_cnt  <= '0;
                        instr_cnt  <= '0;
                        halt_cause <= CAUSE_NONE;
                        hit_idx    <= 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign halt = (state == ST_HALTED);

endmodule

// File: doc/sim_halt_monitor.md
SIM_HALT_MONITOR -- requirements
Module: sim_halt_monitor

Interface
REQ-001 Parameter ADDR_W, default 32, PC/breakpoint address width.
REQ-002 Parameter NUM_BP, default 4, number of halt-address comparators (1..16).
REQ-003 Parameter CNT_W, default 32, cycle/retire counter width.
REQ-004 Parameter LOOP_N, default 8, consecutive identical retired PCs that flag a self-loop.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rstn  in  1  asynchronous active-low reset.
REQ-007 start  in  1  pulse; IDLE->RUN.
REQ-008 clr  in  1  pulse; HALTED->IDLE, counters cleared.
REQ-009 pc  in  ADDR_W  PC of the instruction retiring this cycle.
REQ-010 pc_vld  in  1  retire strobe qualifying pc.
REQ-011 bp_addr  in  NUM_BP*ADDR_W  flattened halt addresses; slot i at bits [i*ADDR_W +: ADDR_W].
REQ-012 bp_en  in  NUM_BP  per-slot enable.
REQ-013 timeout  in  CNT_W  cycle limit in RUN; 0 disables.
REQ-014 halt  out  1  level, high in HALTED.
REQ-015 halt_cause  out  2  00 none, 01 breakpoint, 10 self-loop, 11 timeout.
REQ-016 hit_idx  out  4  lowest matching breakpoint slot.
REQ-017 cycle_cnt  out  CNT_W  cycles spent in RUN.
REQ-018 instr_cnt  out  CNT_W  retired instructions in RUN.

Function
REQ-019 States IDLE, RUN, HALTED; encoding is implementation choice.
REQ-020 IDLE->RUN on start; RUN->HALTED on any halt condition; HALTED->IDLE on clr; start in RUN/HALTED ignored.
REQ-021 In RUN, cycle_cnt increments every cycle; instr_cnt increments on each pc_vld; both saturate at all-ones.
REQ-022 Breakpoint condition: pc_vld and pc == bp_addr[i] and bp_en[i] for any i; hit_idx = lowest such i.
REQ-023 Timeout condition: timeout != 0 and cycle_cnt + 1 == timeout (halt on the timeout-th RUN cycle).
REQ-024 Halt registered: halt, halt_cause, hit_idx update on the edge ending the triggering cycle (1-cycle latency); counters include the triggering cycle/retire.
REQ-025 Simultaneous conditions: priority breakpoint > self-loop > timeout; one cause reported.
REQ-026 In HALTED, counters, halt_cause, hit_idx frozen; pc/pc_vld ignored.
REQ-027 clr and start same cycle in HALTED: clr wins, start ignored (IDLE).
REQ-028 Condition in the same cycle as start from IDLE is ignored; evaluation begins the first RUN cycle.
REQ-029 hit_idx = 0 when halt_cause != 01.

Reset
REQ-030 rstn low asynchronously forces IDLE, halt=0, halt_cause=00, hit_idx=0, cycle_cnt=0, instr_cnt=0, self-loop state cleared, including mid-RUN.
REQ-031 Deassertion takes effect on the next rising clk; block stays IDLE until start.

Configuration
REQ-032 Macro SIM_HALT_MONITOR_LOOP_DETECT_EN defined: self-loop detector present; counts consecutive pc_vld cycles whose pc equals the previous retired pc; fires when count reaches LOOP_N; differing retired pc resets count to 1; non-retire cycles hold count.
REQ-033 Macro undefined: detector and its registers absent; halt_cause 10 never produced; LOOP_N unused.

Verification
REQ-034 Reset, start, retire pc 0x80000000,+4,...; bp_addr[0]=0x80000078, bp_en=0001 -> halt one edge after 0x80000078 retires, halt_cause=01, hit_idx=0, instr_cnt=31.
REQ-035 bp_addr[1]=bp_addr[3]=0x80000010, bp_en=1010 -> hit_idx=1, cause 01.
REQ-036 timeout=100, no retires -> halt after 100th RUN cycle, cycle_cnt=100, cause 11; timeout=0 runs 1000 cycles without halt.
REQ-037 LOOP_DETECT_EN, LOOP_N=8: pc 0x80000040 retired 8 times consecutively -> cause 10; same with bp on 0x80000040 -> cause 01 at first retire.
REQ-038 rstn pulsed low mid-RUN at cycle 50 -> all outputs zero immediately, IDLE; clr+start together in HALTED -> IDLE, counters 0.
